perf_counter_bank: RTL and testbench

// Parametrised bank of event counters for the core and L2 performance events.

---
 rtl/perf_counter_bank_if.sv | 12 +
 rtl/perf_counter_bank.sv | 139 +++++++++++++
 tb/tb_perf_counter_bank.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_bank_if.sv
// Register-access bus between a master and the performance counter bank.
// One access per cycle; read data is returned on the following cycle.
interface io_bus_interface;
    logic [31:0] address;
    logic        read_en;
    logic        write_en;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (output address, read_en, write_en, write_data, input read_data);
    modport slave  (input address, read_en, write_en, write_data, output read_data);
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of selectable, individually enabled event counters with atomic snapshot,
// wrap detection and a maskable level interrupt, mapped as a bus peripheral.
module perf_counter_bank #(
    parameter logic [31:0] BASE_ADDR     = 32'hffff0400,
    parameter int unsigned NUM_EVENTS    = 16,
    parameter int unsigned NUM_COUNTERS  = 4,
    parameter int unsigned COUNTER_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] perf_events,
    io_bus_interface.slave        io_bus,
    output logic                  perf_irq
);
    localparam int unsigned NC   = NUM_COUNTERS;
    localparam int unsigned CW   = COUNTER_WIDTH;
    localparam int unsigned HI_W = CW - 32;

    logic [NC-1:0]  ctrl_q, ctrl_d, ovf_q, ovf_d, mask_q, mask_d;
    logic [NC-1:0]  ovf_set, ovf_clr;
    logic [7:0]     sel_q  [NC];
    logic [7:0]     sel_d  [NC];
    logic [CW-1:0]  cnt_q  [NC];
    logic [CW-1:0]  cnt_d  [NC];
    logic [CW-1:0]  snap_q [NC];
    logic [CW-1:0]  snap_d [NC];
    logic [31:0]    rdata_q, rdata_d;
    logic           irq_q;
    logic           snap_wr;

    logic           hit, cnt_hit, wr;
    logic [10:0]    off;
    logic [5:0]     blk, cidx;
    logic [4:0]     sub;
    logic [255:0]   ev_ext;

    // Offsets are relative to BASE_ADDR; addresses below it in the same 2 KB block do not decode.
    assign hit     = (io_bus.address[31:11] == BASE_ADDR[31:11]) &&
                     (io_bus.address[10:0] >= BASE_ADDR[10:0]);
    assign off     = io_bus.address[10:0] - BASE_ADDR[10:0];
    assign blk     = off[10:5];
    assign cidx    = blk - 6'd2;
    assign sub     = off[4:0];
    assign cnt_hit = hit && (blk >= 6'd2) && (32'(cidx) < NC);
    assign wr      = io_bus.write_en && hit;
    // Zero padding makes any SEL >= NUM_EVENTS select a line that never fires.
    assign ev_ext  = 256'(perf_events);

    always_comb begin : next_state
        ctrl_d  = ctrl_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        ovf_set = '0;
        ovf_clr = '0;
        snap_wr = 1'b0;
        if (wr) begin
            case (off)
                11'h000: ctrl_d  = io_bus.write_data[NC-1:0];
                11'h004: ovf_clr = io_bus.write_data[NC-1:0];
                11'h008: mask_d  = io_bus.write_data[NC-1:0];
                11'h00c: snap_wr = 1'b1;
                default: ;
            endcase
        end
        // A register write to a counter takes precedence over its increment.
        for (int i = 0; i < int'(NC); i++) begin
            if (wr && cnt_hit && cidx == 6'(i) && sub == 5'h04) begin
                cnt_d[i][31:0] = io_bus.write_data;
            end else if (wr && cnt_hit && cidx == 6'(i) && sub == 5'h08) begin
                cnt_d[i][CW-1:32] = io_bus.write_data[HI_W-1:0];
            end else if (ctrl_q[i] && ev_ext[sel_q[i]]) begin
                cnt_d[i]   = cnt_q[i] + CW'(1);
                ovf_set[i] = &cnt_q[i];
            end
            if (wr && cnt_hit && cidx == 6'(i) && sub == 5'h00) begin
                sel_d[i] = io_bus.write_data[7:0];
            end
        end
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
        if (snap_wr) begin
            snap_d = cnt_d;
        end
    end

    always_comb begin : read_mux
        rdata_d = '0;
        if (io_bus.read_en && hit) begin
            case (off)
                11'h000: rdata_d = 32'(ctrl_q);
                11'h004: rdata_d = 32'(ovf_q);
                11'h008: rdata_d = 32'(mask_q);
                default: ;
            endcase
            if (cnt_hit) begin
                for (int i = 0; i < int'(NC); i++) begin
                    if (cidx == 6'(i)) begin
                        case (sub)
                            5'h00:   rdata_d = 32'(sel_q[i]);
                            5'h04:   rdata_d = cnt_q[i][31:0];
                            5'h08:   rdata_d = 32'(cnt_q[i][CW-1:32]);
                            5'h10:   rdata_d = snap_q[i][31:0];
                            5'h14:   rdata_d = 32'(snap_q[i][CW-1:32]);
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= '0;
            ovf_q   <= '0;
            mask_q  <= '0;
            for (int i = 0; i < int'(NC); i++) begin
                sel_q[i]  <= '0;
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            rdata_q <= rdata_d;
            irq_q   <= |(ovf_q & mask_q);
        end
    end

    assign io_bus.read_data = rdata_q;
    assign perf_irq         = irq_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomised and directed checks of perf_counter_bank against a behavioural
// register/counter model.
module tb_perf_counter_bank;
    localparam int unsigned NE = 16;
    localparam int unsigned NC = 4;
    localparam int unsigned CW = 48;
    localparam logic [31:0] BASE = 32'hffff0400;
    localparam longint unsigned CMAX   = (64'd1 << CW) - 1;
    localparam longint unsigned HIMASK = (64'd1 << (CW - 32)) - 1;
    localparam int unsigned NCMASK = (1 << NC) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NE-1:0] ev;
    logic          irq;
    io_bus_interface bus();

    perf_counter_bank #(
        .BASE_ADDR(BASE), .NUM_EVENTS(NE), .NUM_COUNTERS(NC), .COUNTER_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .perf_events(ev), .io_bus(bus), .perf_irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    int unsigned     m_ctrl, m_ovf, m_mask;
    int unsigned     m_sel  [NC];
    longint unsigned m_cnt  [NC];
    longint unsigned m_snap [NC];
    logic [31:0]     m_rdata;
    logic            m_irq;

    task automatic model_reset();
        m_ctrl = 0; m_ovf = 0; m_mask = 0; m_rdata = '0; m_irq = 1'b0;
        for (int i = 0; i < int'(NC); i++) begin
            m_sel[i] = 0; m_cnt[i] = 0; m_snap[i] = 0;
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return ((a >> 11) == (BASE >> 11)) && (a >= BASE);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int unsigned off, i, r;
        if (!m_hit(a)) return '0;
        off = a - BASE;
        if (off == 0) return m_ctrl;
        if (off == 4) return m_ovf;
        if (off == 8) return m_mask;
        if (off >= 32'h40) begin
            i = (off - 32'h40) / 32;
            r = (off - 32'h40) % 32;
            if (i < NC) begin
                if (r == 0)  return m_sel[i];
                if (r == 4)  return 32'(m_cnt[i]);
                if (r == 8)  return 32'(m_cnt[i] >> 32);
                if (r == 16) return 32'(m_snap[i]);
                if (r == 20) return 32'(m_snap[i] >> 32);
            end
        end
        return '0;
    endfunction

    task automatic model_step(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [NE-1:0] e);
        bit inc [NC];
        bit written [NC];
        int unsigned off, i, r, set_b, clr_b;
        bit snap;
        set_b = 0; clr_b = 0; snap = 0;
        m_irq   = (m_ovf & m_mask) != 0;
        m_rdata = rd ? m_read(a) : '0;
        for (int k = 0; k < int'(NC); k++) begin
            inc[k]     = ((m_ctrl >> k) & 1) == 1 && m_sel[k] < NE && e[m_sel[k]] == 1'b1;
            written[k] = 0;
        end
        if (wr && m_hit(a)) begin
            off = a - BASE;
            if (off == 0) m_ctrl = wd & NCMASK;
            if (off == 4) clr_b = wd & NCMASK;
            if (off == 8) m_mask = wd & NCMASK;
            if (off == 12) snap = 1;
            if (off >= 32'h40) begin
                i = (off - 32'h40) / 32;
                r = (off - 32'h40) % 32;
                if (i < NC) begin
                    if (r == 0) m_sel[i] = wd & 32'hff;
                    if (r == 4) begin
                        m_cnt[i] = (m_cnt[i] & ~64'hffffffff) | longint'(wd);
                        written[i] = 1;
                    end
                    if (r == 8) begin
                        m_cnt[i] = (m_cnt[i] & 64'hffffffff) | ((longint'(wd) & HIMASK) << 32);
                        written[i] = 1;
                    end
                end
            end
        end
        for (int k = 0; k < int'(NC); k++) begin
            if (inc[k] && !written[k]) begin
                if (m_cnt[k] == CMAX) begin
                    m_cnt[k] = 0;
                    set_b |= (1 << k);
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
        m_ovf = (m_ovf & ~clr_b) | set_b;
        if (snap) for (int k = 0; k < int'(NC); k++) m_snap[k] = m_cnt[k];
    endtask

    task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [NE-1:0] e);
        logic [31:0] prev;
        @(negedge clk);
        prev = m_rdata;
        bus.read_en = rd; bus.write_en = wr; bus.address = a; bus.write_data = wd; ev = e;
        model_step(rd, wr, a, wd, e);
        #1 check("rd_hold", bus.read_data, prev);
        @(posedge clk);
        #1;
        check($sformatf("rd@%h", a), bus.read_data, m_rdata);
        check("irq", irq, m_irq);
    endtask

    task automatic wr_reg(input int unsigned off, input logic [31:0] d, input logic [NE-1:0] e = '0);
        bus_cycle(1'b0, 1'b1, BASE + off, d, e);
    endtask

    task automatic rd_reg(input int unsigned off, input logic [NE-1:0] e = '0);
        bus_cycle(1'b1, 1'b0, BASE + off, '0, e);
    endtask

    task automatic idle(input logic [NE-1:0] e = '0);
        bus_cycle(1'b0, 1'b0, BASE, '0, e);
    endtask

    int unsigned offs[$];

    initial begin
        reset = 1'b1; ev = '0;
        bus.read_en = 1'b0; bus.write_en = 1'b0; bus.address = '0; bus.write_data = '0;
        model_reset();
        offs = '{32'h0, 32'h4, 32'h8, 32'hc};
        for (int i = 0; i < int'(NC); i++) begin
            offs.push_back(32'h40 + 32 * i);
            offs.push_back(32'h44 + 32 * i);
            offs.push_back(32'h48 + 32 * i);
            offs.push_back(32'h50 + 32 * i);
            offs.push_back(32'h54 + 32 * i);
        end
        repeat (2) @(negedge clk);
        check("reset_rdata", bus.read_data, 0);
        check("reset_irq", irq, 0);
        reset = 1'b0;

        // 1: every register reads 0 after reset, one cycle after read_en
        foreach (offs[j]) rd_reg(offs[j]);
        wr_reg(32'h0, 32'h5);
        rd_reg(32'h0);
        check("t1_latency", bus.read_data, 5);
        wr_reg(32'h0, 32'h0);

        // 2: counter 0 on event 3 with neighbours toggling
        wr_reg(32'h40, 3);
        wr_reg(32'h0, 1);
        for (int k = 0; k < 10; k++) idle(NE'(32'h8 | ($urandom & 32'h14)));
        rd_reg(32'h44);
        check("t2_cnt0", bus.read_data, 10);
        rd_reg(32'h64);
        check("t2_cnt1", bus.read_data, 0);
        rd_reg(32'ha4);

        // 3: wrap, overflow flag, interrupt and W1C
        wr_reg(32'h44, 32'hffffffff);
        wr_reg(32'h48, 32'h0000ffff);
        wr_reg(32'h8, 1);
        idle(NE'(32'h8));
        rd_reg(32'h4);
        check("t3_ovf", bus.read_data, 1);
        check("t3_irq", irq, 1);
        rd_reg(32'h44);
        check("t3_cnt_lo", bus.read_data, 0);
        rd_reg(32'h48);
        check("t3_cnt_hi", bus.read_data, 0);
        wr_reg(32'h4, 1);
        idle(); idle();
        check("t3_irq_clr", irq, 0);

        // 4: snapshot captures the post-increment value
        wr_reg(32'h60, 5);
        wr_reg(32'h0, 2);
        for (int k = 0; k < 200 && m_cnt[1] < 100; k++) idle(NE'(32'h20));
        check("t4_live100", 32'(m_cnt[1]), 100);
        wr_reg(32'hc, 32'hdeadbeef, NE'(32'h20));
        rd_reg(32'h70, NE'(32'h20));
        check("t4_snap", bus.read_data, 101);
        rd_reg(32'h64, NE'(32'h20));
        check("t4_live", bus.read_data, 102);

        // 5: write beats increment; set beats W1C
        wr_reg(32'h0, 4);
        wr_reg(32'h80, 7);
        wr_reg(32'h84, 5, NE'(32'h80));
        rd_reg(32'h84);
        check("t5_wr_wins", bus.read_data, 5);
        wr_reg(32'h84, 32'hffffffff);
        wr_reg(32'h88, 32'hffffffff);
        wr_reg(32'h4, 4, NE'(32'h80));
        rd_reg(32'h4);
        check("t5_set_wins", bus.read_data, 4);

        // 6: out-of-range SEL and out-of-window addresses
        wr_reg(32'ha0, NE);
        wr_reg(32'h0, 8);
        for (int k = 0; k < 5; k++) idle('1);
        rd_reg(32'ha4);
        check("t6_nocount", bus.read_data, 0);
        wr_reg(32'h7fc, 32'hffffffff);
        wr_reg(32'h800, 32'hffffffff);
        bus_cycle(1'b0, 1'b1, BASE - 4, 32'hffffffff, '0);
        rd_reg(32'h7fc);
        check("t6_7fc", bus.read_data, 0);
        rd_reg(32'h800);
        check("t6_800", bus.read_data, 0);
        rd_reg(32'h0);
        check("t6_ctrl", bus.read_data, 8);

        // Randomised traffic
        offs.push_back(32'h7fc); offs.push_back(32'h800); offs.push_back(32'hc0);
        wr_reg(32'h8, 32'hf);
        for (int k = 0; k < 400; k++) begin
            int unsigned op, o;
            logic [31:0] wd;
            op = $urandom_range(0, 3);
            o  = offs[$urandom_range(0, offs.size() - 1)];
            wd = ($urandom_range(0, 3) == 0) ? 32'hffffffff : $urandom;
            if (o >= 32'h40 && ((o - 32'h40) % 32) == 0) wd = $urandom_range(0, NE + 3);
            bus_cycle(op == 1 || op == 3, op == 2 || op == 3, BASE + o, wd, NE'($urandom));
        end

        // 7: reset during an in-flight read
        wr_reg(32'h0, 32'hf);
        rd_reg(32'h0);
        check("t7_pre", bus.read_data, 32'hf);
        @(negedge clk);
        bus.read_en = 1'b1; bus.write_en = 1'b0; bus.address = BASE;
        #1 reset = 1'b1;
        #1 check("t7_async", bus.read_data, 0);
        model_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0; bus.read_en = 1'b0;
        @(posedge clk); #1;
        check("t7_no_stale", bus.read_data, 0);
        check("t7_irq", irq, 0);
        rd_reg(32'h0);
        check("t7_ctrl", bus.read_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
